// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/op definitions plus alg sequencer state and default latencies.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   localparam logic [2:0] op_mul = 3'b110;
   localparam logic [2:0] op_div = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} alg_seq_state_t;

   localparam int ALG_MUL_CYCLES = 4;
   localparam int ALG_DIV_CYCLES = 8;

endpackage

// File: rtl/alg_cycle_counter.sv
// alg_cycle_counter: loadable down-counter that holds at zero and flags it.
module alg_cycle_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/alg_seq_ctrl.sv
// alg_seq_ctrl: multicycle issue/writeback sequencer for the mul/div unit.
// Optional ALG_DIV_ZERO_TRAP_EN: divide-by-zero completes immediately with a div0 pulse.
module alg_seq_ctrl
   import lc3b_types::*;
#(
   parameter int MUL_CYCLES = ALG_MUL_CYCLES,
   parameter int DIV_CYCLES = ALG_DIV_CYCLES
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     start,
   input  logic [2:0] op_x,
   input  lc3b_word src_a,
   input  lc3b_word src_b,
   input  logic     flush,
   output lc3b_word alg_opA,
   output lc3b_word alg_opB,
   output logic [2:0] alg_op_x,
   input  lc3b_word alg_hi,
   input  lc3b_word alg_lo,
   output logic     stall,
   output logic     done,
`ifdef ALG_DIV_ZERO_TRAP_EN
   output logic     div0,
`endif
   output lc3b_word hi,
   output lc3b_word lo
);

   localparam int CW = $clog2(MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1;
   localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

   alg_seq_state_t state_q, state_d;
   lc3b_word a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [2:0] op_q, op_d;
   logic accept, dz, ld, dec, zero;

   assign accept = start && !flush && (op_x == op_mul || op_x == op_div);

`ifdef ALG_DIV_ZERO_TRAP_EN
   logic div0_q, div0_d;
   assign dz   = (op_x == op_div) && (src_b == '0);
   assign div0 = (state_q == DONE) && div0_q;
`else
   assign dz = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      stall   = 1'b0;
      ld      = 1'b0;
      dec     = 1'b0;
`ifdef ALG_DIV_ZERO_TRAP_EN
      div0_d  = div0_q;
`endif
      case (state_q)
         IDLE: if (accept) begin
            a_d     = src_a;
            b_d     = src_b;
            op_d    = op_x;
            ld      = 1'b1;
            stall   = 1'b1;
            state_d = dz ? DONE : BUSY;
`ifdef ALG_DIV_ZERO_TRAP_EN
            div0_d  = dz;
`endif
         end
         BUSY: begin
            stall = 1'b1;
            if (flush) state_d = IDLE;
            else if (zero) begin
               hi_d    = alg_hi;
               lo_d    = alg_lo;
               state_d = DONE;
            end else dec = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef ALG_DIV_ZERO_TRAP_EN
         div0_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef ALG_DIV_ZERO_TRAP_EN
         div0_q  <= div0_d;
`endif
      end

   alg_cycle_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (ld),
      .load_val (op_x == op_mul ? MUL_LD : DIV_LD),
      .dec      (dec),
      .zero     (zero)
   );

   assign done     = (state_q == DONE);
   assign alg_opA  = a_q;
   assign alg_opB  = b_q;
   assign alg_op_x = op_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_alg_seq_ctrl.sv
// tb_alg_seq_ctrl: directed + randomized bench against a cycles-until-done reference model.
module tb_alg_seq_ctrl;
   import lc3b_types::*;

   localparam int N_MUL = 4;
   localparam int N_DIV = 8;

   logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
   logic [2:0] op_x = 3'd0;
   logic [15:0] src_a = 16'd0, src_b = 16'd0;
   logic [15:0] alg_opA, alg_opB, alg_hi, alg_lo, hi, lo;
   logic [2:0] alg_op_x;
   logic stall, done, d0_obs;
`ifdef ALG_DIV_ZERO_TRAP_EN
   logic div0;
`endif

   int tests = 0, failed = 0;
   bit chk_en = 1'b0;

   alg_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .op_x(op_x), .src_a(src_a), .src_b(src_b),
      .flush(flush), .alg_opA(alg_opA), .alg_opB(alg_opB), .alg_op_x(alg_op_x),
      .alg_hi(alg_hi), .alg_lo(alg_lo), .stall(stall), .done(done),
`ifdef ALG_DIV_ZERO_TRAP_EN
      .div0(div0),
`endif
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alg_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      if (op == op_mul) return 32'(a) * 32'(b);
      if (op == op_div) return (b == 16'd0) ? {a, 16'hFFFF} : {a % b, a / b};
      return 32'd0;
   endfunction

   always_comb {alg_hi, alg_lo} = alg_ref(alg_op_x, alg_opA, alg_opB);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s got=%h exp=%h @%0t", nm, act, exp, $time);
      end
   endtask

   // Model: m_due = cycles until the done pulse (0 = done now, -1 = idle).
   int m_due;
   logic [15:0] m_a, m_b, m_hi, m_lo;
   logic [2:0] m_op;
   logic m_div0;
   wire acc_now = start && !flush && (op_x == op_mul || op_x == op_div);

   always @(posedge clk or posedge reset)
      if (reset) begin
         m_due <= -1; m_a <= '0; m_b <= '0; m_op <= '0; m_hi <= '0; m_lo <= '0; m_div0 <= 1'b0;
      end else if (m_due < 0) begin
         if (acc_now) begin
            m_a <= src_a; m_b <= src_b; m_op <= op_x;
`ifdef ALG_DIV_ZERO_TRAP_EN
            if (op_x == op_div && src_b == 16'd0) begin m_due <= 0; m_div0 <= 1'b1; end else
`endif
            begin m_due <= (op_x == op_mul) ? N_MUL : N_DIV; m_div0 <= 1'b0; end
         end
      end else if (m_due == 0) m_due <= -1;
      else if (flush) m_due <= -1;
      else begin
         if (m_due == 1) {m_hi, m_lo} <= alg_ref(m_op, m_a, m_b);
         m_due <= m_due - 1;
      end

   always @(negedge clk)
      if (chk_en && !reset) begin
         chk("stall", 32'(stall), 32'((m_due < 0 && acc_now) || m_due > 0));
         chk("done", 32'(done), 32'(m_due == 0));
         chk("alg_ops", {alg_op_x, alg_opA, alg_opB}, {m_op, m_a, m_b});
         chk("hilo", {hi, lo}, {m_hi, m_lo});
`ifdef ALG_DIV_ZERO_TRAP_EN
         chk("div0", 32'(div0), 32'(m_due == 0 && m_div0));
`endif
      end

   task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int exp_sc);
      int sc;
      bit got;
      sc = 0; got = 1'b0; d0_obs = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; op_x = op; src_a = a; src_b = b;
      @(negedge clk); if (stall) sc++;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (stall) sc++;
         if (done) begin
            got = 1'b1;
`ifdef ALG_DIV_ZERO_TRAP_EN
            d0_obs = div0;
`endif
            break;
         end
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("stall_cycles", 32'(sc), 32'(exp_sc));
   endtask

   initial begin
      logic [15:0] ra, rb;
      #3;
      chk("rst_outs", {stall, done, alg_op_x, alg_opA}, 32'd0);
      chk("rst_hilo", {hi, lo}, 32'd0);
      chk("rst_opB", 32'(alg_opB), 32'd0);
      @(posedge clk); #1 reset = 1'b0; chk_en = 1'b1;

      do_op(op_mul, 16'h1234, 16'h0010, N_MUL + 1);
      chk("mul_hilo", {hi, lo}, 32'h0001_2340);

      @(posedge clk); #1 start = 1'b1; op_x = op_mul; src_a = 16'd5; src_b = 16'd6;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk) chk("flush_idle", {31'd0, stall}, 32'd0);
      for (int i = 0; i < 12; i++) @(negedge clk) chk("flush_nodone", 32'(done), 32'd0);
      chk("flush_hilo", {hi, lo}, 32'h0001_2340);

      do_op(op_div, 16'd100, 16'd7, N_DIV + 1);
      chk("div_hilo", {hi, lo}, 32'h0002_000E);

`ifdef ALG_DIV_ZERO_TRAP_EN
      do_op(op_div, 16'd50, 16'd0, 1);
      chk("div0_pulse", 32'(d0_obs), 32'd1);
      chk("div0_hilo", {hi, lo}, 32'h0002_000E);
`else
      do_op(op_div, 16'd50, 16'd0, N_DIV + 1);
      chk("divz_hilo", {hi, lo}, 32'h0032_FFFF);
`endif

      ra = 16'($urandom); rb = 16'($urandom);
      do_op(op_mul, ra, rb, N_MUL + 1);
      chk("b2b_mul", {hi, lo}, 32'(ra) * 32'(rb));
      rb = 16'($urandom_range(1, 65535));
      do_op(op_div, ra, rb, N_DIV + 1);
      chk("b2b_div", {hi, lo}, {ra % rb, ra / rb});

      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1 start = 1'b1; op_x = 3'(i % 6);
         @(negedge clk);
         chk("inv_stall", 32'(stall), 32'd0);
         chk("inv_done", 32'(done), 32'd0);
      end
      @(posedge clk); #1 start = 1'b0;

      @(posedge clk); #1 start = 1'b1; op_x = op_mul; src_a = 16'd9; src_b = 16'd9;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #3 reset = 1'b1;
      #1;
      chk("arst_ctl", {30'd0, stall, done}, 32'd0);
      chk("arst_hilo", {hi, lo}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      do_op(op_mul, 16'd3, 16'd4, N_MUL + 1);
      chk("arst_after", {hi, lo}, 32'd12);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         start = ($urandom % 3 == 0);
         op_x  = ($urandom % 4 == 0) ? 3'($urandom) : (($urandom % 2 == 0) ? op_mul : op_div);
         src_a = 16'($urandom);
         src_b = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom);
         flush = ($urandom % 16 == 0);
      end
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
